// File: rtl/multi_run_tracker_pkg.sv
// Shared types for the multi-channel run tracker: trend codes, report FSM
// encoding and the clamping adder used by every channel accumulator.
package multi_run_pkg;

    typedef enum logic [1:0] {
        HR_SAME   = 2'b00,
        HR_HIGHER = 2'b01,
        HR_LOWER  = 2'b10
    } hr_trend_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SAT_W = 64;

    // Result bits [w-1:0] hold the clamped sum; any set bit at or above w means it clamped.
    function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
        logic [SAT_W:0]   sum;
        logic [SAT_W-1:0] lim;
        lim = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) sat_add = {1'b1, lim};
        else                   sat_add = sum;
    endfunction

endpackage

// File: rtl/multi_run_tracker_if.sv
// Report handshake between the leader-scan FSM and its requester.
interface multi_run_tracker_if #(
    parameter int NUM_RUNS = 2,
    parameter int DIST_W   = 32
);
    localparam int IDX_W = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1;

    logic              report_req;
    logic              report_busy;
    logic              report_valid;
    logic [IDX_W-1:0]  leader_idx;
    logic [DIST_W-1:0] leader_distance;

    modport master (output report_req,
                    input  report_busy, report_valid, leader_idx, leader_distance);
    modport slave  (input  report_req,
                    output report_busy, report_valid, leader_idx, leader_distance);
endinterface

// File: rtl/multi_run_tracker_accum.sv
// One run channel: saturating totals, peak HR, and trend/feedback against
// the previous accepted sample.
module run_accumulator
    import multi_run_pkg::*;
#(
    parameter int HR_W     = 8,
    parameter int SPS_W    = 3,
    parameter int STRIDE_W = 8,
    parameter int STEP_W   = 16,
    parameter int DIST_W   = 32,
    parameter int TIME_W   = 8,
    parameter int HR_HYST  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                valid_i,
    input  logic [HR_W-1:0]     hr_i,
    input  logic [SPS_W-1:0]    sps_i,
    input  logic [STRIDE_W-1:0] stride_i,
    output logic [STEP_W-1:0]   steps_o,
    output logic [DIST_W-1:0]   dist_o,
    output logic [TIME_W-1:0]   time_o,
    output logic [HR_W-1:0]     maxhr_o,
    output logic [1:0]          trend_o,
    output logic                fb_o,
    output logic                sat_o
);
    localparam int PROD_W = SPS_W + STRIDE_W;

    logic [STEP_W-1:0] steps_q, steps_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [HR_W-1:0]   maxhr_q, maxhr_d, prev_hr_q, prev_hr_d;
    logic [SPS_W-1:0]  prev_sps_q, prev_sps_d;
    logic [1:0]        trend_q, trend_d;
    logic              fb_q, fb_d, sat_q, sat_d, seen_q, seen_d;

    logic [PROD_W-1:0] prod;
    logic [SAT_W:0]    steps_r, dist_r, time_r;
    logic              ovf;
    logic [HR_W:0]     hr_x, prev_x, hyst;

    always_comb begin
        prod    = PROD_W'(sps_i) * PROD_W'(stride_i);
        steps_r = sat_add(SAT_W'(steps_q), SAT_W'(sps_i), STEP_W);
        dist_r  = sat_add(SAT_W'(dist_q), SAT_W'(prod), DIST_W);
        time_r  = sat_add(SAT_W'(time_q), SAT_W'(1), TIME_W);
        ovf     = (|steps_r[SAT_W:STEP_W]) | (|dist_r[SAT_W:DIST_W]) | (|time_r[SAT_W:TIME_W]);
        // One extra bit so prev+hyst and hr+hyst cannot wrap near full scale.
        hr_x    = {1'b0, hr_i};
        prev_x  = {1'b0, prev_hr_q};
        hyst    = (HR_W+1)'(HR_HYST);

        steps_d    = steps_q;
        dist_d     = dist_q;
        time_d     = time_q;
        maxhr_d    = maxhr_q;
        prev_hr_d  = prev_hr_q;
        prev_sps_d = prev_sps_q;
        trend_d    = trend_q;
        fb_d       = fb_q;
        sat_d      = sat_q;
        seen_d     = seen_q;

        if (clear_i) begin
            steps_d    = '0;
            dist_d     = '0;
            time_d     = '0;
            maxhr_d    = '0;
            prev_hr_d  = '0;
            prev_sps_d = '0;
            trend_d    = HR_SAME;
            fb_d       = 1'b0;
            sat_d      = 1'b0;
            seen_d     = 1'b0;
        end else if (valid_i) begin
            steps_d    = steps_r[STEP_W-1:0];
            dist_d     = dist_r[DIST_W-1:0];
            time_d     = time_r[TIME_W-1:0];
            maxhr_d    = (hr_i > maxhr_q) ? hr_i : maxhr_q;
            prev_hr_d  = hr_i;
            prev_sps_d = sps_i;
            sat_d      = sat_q | ovf;
            seen_d     = 1'b1;
            fb_d       = !seen_q || (sps_i >= prev_sps_q);
            if (!seen_q)                  trend_d = HR_SAME;
            else if (hr_x > prev_x + hyst) trend_d = HR_HIGHER;
            else if (hr_x + hyst < prev_x) trend_d = HR_LOWER;
            else                           trend_d = HR_SAME;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            steps_q    <= '0;
            dist_q     <= '0;
            time_q     <= '0;
            maxhr_q    <= '0;
            prev_hr_q  <= '0;
            prev_sps_q <= '0;
            trend_q    <= HR_SAME;
            fb_q       <= 1'b0;
            sat_q      <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            steps_q    <= steps_d;
            dist_q     <= dist_d;
            time_q     <= time_d;
            maxhr_q    <= maxhr_d;
            prev_hr_q  <= prev_hr_d;
            prev_sps_q <= prev_sps_d;
            trend_q    <= trend_d;
            fb_q       <= fb_d;
            sat_q      <= sat_d;
            seen_q     <= seen_d;
        end
    end

    assign steps_o = steps_q;
    assign dist_o  = dist_q;
    assign time_o  = time_q;
    assign maxhr_o = maxhr_q;
    assign trend_o = trend_q;
    assign fb_o    = fb_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/multi_run_tracker.sv
// N-channel run tracker: per-channel accumulators plus a leader scan that
// walks a distance snapshot one channel per cycle.
module multi_run_tracker
    import multi_run_pkg::*;
#(
    parameter int NUM_RUNS = 2,
    parameter int HR_W     = 8,
    parameter int SPS_W    = 3,
    parameter int STRIDE_W = 8,
    parameter int STEP_W   = 16,
    parameter int DIST_W   = 32,
    parameter int TIME_W   = 8,
    parameter int HR_HYST  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RUNS-1:0]          sample_valid,
    input  logic [NUM_RUNS*HR_W-1:0]     hr_in,
    input  logic [NUM_RUNS*SPS_W-1:0]    sps_in,
    input  logic [NUM_RUNS*STRIDE_W-1:0] stride_in,
    input  logic [NUM_RUNS-1:0]          clear_run,
    multi_run_tracker_if.slave           rpt,
    output logic [NUM_RUNS*STEP_W-1:0]   total_steps,
    output logic [NUM_RUNS*DIST_W-1:0]   total_distance,
    output logic [NUM_RUNS*TIME_W-1:0]   time_elapsed,
    output logic [NUM_RUNS*HR_W-1:0]     max_hr,
    output logic [NUM_RUNS*2-1:0]        hr_trend,
    output logic [NUM_RUNS-1:0]          step_feedback,
    output logic [NUM_RUNS-1:0]          sat_flag
);
    localparam int IDX_W = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RUNS - 1);

    logic [NUM_RUNS-1:0][DIST_W-1:0] dist_w;

    for (genvar g = 0; g < NUM_RUNS; g++) begin : g_run
        run_accumulator #(
            .HR_W(HR_W), .SPS_W(SPS_W), .STRIDE_W(STRIDE_W), .STEP_W(STEP_W),
            .DIST_W(DIST_W), .TIME_W(TIME_W), .HR_HYST(HR_HYST)
        ) u_run (
            .clk     (clk),
            .rst     (rst),
            .clear_i (clear_run[g]),
            .valid_i (sample_valid[g]),
            .hr_i    (hr_in[g*HR_W +: HR_W]),
            .sps_i   (sps_in[g*SPS_W +: SPS_W]),
            .stride_i(stride_in[g*STRIDE_W +: STRIDE_W]),
            .steps_o (total_steps[g*STEP_W +: STEP_W]),
            .dist_o  (dist_w[g]),
            .time_o  (time_elapsed[g*TIME_W +: TIME_W]),
            .maxhr_o (max_hr[g*HR_W +: HR_W]),
            .trend_o (hr_trend[g*2 +: 2]),
            .fb_o    (step_feedback[g]),
            .sat_o   (sat_flag[g])
        );
        assign total_distance[g*DIST_W +: DIST_W] = dist_w[g];
    end

    logic [1:0]                      state_q, state_d;
    logic [IDX_W-1:0]                scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]                best_idx_q, best_idx_d, leader_idx_q, leader_idx_d;
    logic [DIST_W-1:0]               best_dist_q, best_dist_d, leader_dist_q, leader_dist_d;
    logic [NUM_RUNS-1:0][DIST_W-1:0] snap_q, snap_d;

    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        best_idx_d    = best_idx_q;
        best_dist_d   = best_dist_q;
        leader_idx_d  = leader_idx_q;
        leader_dist_d = leader_dist_q;
        snap_d        = snap_q;
        case (state_q)
            ST_IDLE: if (rpt.report_req) begin
                snap_d      = dist_w;
                scan_idx_d  = '0;
                best_idx_d  = '0;
                best_dist_d = '0;
                state_d     = ST_SCAN;
            end
            ST_SCAN: begin
                // Strictly greater only, so ties stay with the lower channel.
                if (snap_q[scan_idx_q] > best_dist_q) begin
                    best_idx_d  = scan_idx_q;
                    best_dist_d = snap_q[scan_idx_q];
                end
                if (scan_idx_q == LAST_IDX) begin
                    leader_idx_d  = best_idx_d;
                    leader_dist_d = best_dist_d;
                    state_d       = ST_DONE;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            scan_idx_q    <= '0;
            best_idx_q    <= '0;
            best_dist_q   <= '0;
            leader_idx_q  <= '0;
            leader_dist_q <= '0;
            snap_q        <= '0;
        end else begin
            state_q       <= state_d;
            scan_idx_q    <= scan_idx_d;
            best_idx_q    <= best_idx_d;
            best_dist_q   <= best_dist_d;
            leader_idx_q  <= leader_idx_d;
            leader_dist_q <= leader_dist_d;
            snap_q        <= snap_d;
        end
    end

    assign rpt.report_busy     = (state_q == ST_SCAN);
    assign rpt.report_valid    = (state_q == ST_DONE);
    assign rpt.leader_idx      = leader_idx_q;
    assign rpt.leader_distance = leader_dist_q;

endmodule

// File: tb/tb_multi_run_tracker.sv
// Bench for multi_run_tracker: 4 channels with a 12-bit distance so both the
// leader scan and distance clamping are reachable with short sequences.
module tb_multi_run_tracker;
    localparam int N     = 4;
    localparam int DW    = 12;
    localparam int DMAX  = 4095;
    localparam int SMAX  = 65535;
    localparam int TMAX  = 255;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   sample_valid, clear_run;
    logic [N*8-1:0] hr_in, stride_in;
    logic [N*3-1:0] sps_in;
    logic [N*16-1:0] total_steps;
    logic [N*DW-1:0] total_distance;
    logic [N*8-1:0] time_elapsed, max_hr;
    logic [N*2-1:0] hr_trend;
    logic [N-1:0]   step_feedback, sat_flag;

    multi_run_tracker_if #(.NUM_RUNS(N), .DIST_W(DW)) rpt();

    multi_run_tracker #(.NUM_RUNS(N), .DIST_W(DW)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .hr_in(hr_in),
        .sps_in(sps_in), .stride_in(stride_in), .clear_run(clear_run), .rpt(rpt),
        .total_steps(total_steps), .total_distance(total_distance),
        .time_elapsed(time_elapsed), .max_hr(max_hr), .hr_trend(hr_trend),
        .step_feedback(step_feedback), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: totals as plain integers clamped at their maxima,
    // leader chosen by a direct argmax over the distances seen at request time.
    int m_steps[N], m_dist[N], m_time[N], m_max[N], m_phr[N], m_psps[N], m_trend[N];
    bit m_seen[N], m_fb[N], m_sat[N];
    int m_cnt, m_lidx, m_ldist, p_idx, p_dist;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_steps[i] = 0; m_dist[i] = 0; m_time[i] = 0; m_max[i] = 0;
                m_phr[i] = 0; m_psps[i] = 0; m_trend[i] = 0;
                m_seen[i] = 0; m_fb[i] = 0; m_sat[i] = 0;
            end
            m_cnt = 0; m_lidx = 0; m_ldist = 0; p_idx = 0; p_dist = 0;
        end else begin
            if (m_cnt == 0 && rpt.report_req) begin
                p_idx = 0; p_dist = 0;
                for (int i = 0; i < N; i++)
                    if (m_dist[i] > p_dist) begin p_idx = i; p_dist = m_dist[i]; end
                m_cnt = N + 1;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 1) begin m_lidx = p_idx; m_ldist = p_dist; end
            end
            for (int i = 0; i < N; i++) begin
                int hr, sps, st;
                hr  = int'(hr_in[i*8 +: 8]);
                sps = int'(sps_in[i*3 +: 3]);
                st  = int'(stride_in[i*8 +: 8]);
                if (clear_run[i]) begin
                    m_steps[i] = 0; m_dist[i] = 0; m_time[i] = 0; m_max[i] = 0;
                    m_phr[i] = 0; m_psps[i] = 0; m_trend[i] = 0;
                    m_seen[i] = 0; m_fb[i] = 0; m_sat[i] = 0;
                end else if (sample_valid[i]) begin
                    m_steps[i] += sps;
                    m_dist[i]  += sps * st;
                    m_time[i]  += 1;
                    if (m_steps[i] > SMAX) begin m_steps[i] = SMAX; m_sat[i] = 1; end
                    if (m_dist[i] > DMAX)  begin m_dist[i] = DMAX;  m_sat[i] = 1; end
                    if (m_time[i] > TMAX)  begin m_time[i] = TMAX;  m_sat[i] = 1; end
                    if (hr > m_max[i]) m_max[i] = hr;
                    if (!m_seen[i])            m_trend[i] = 0;
                    else if (hr > m_phr[i] + 2) m_trend[i] = 1;
                    else if (hr + 2 < m_phr[i]) m_trend[i] = 2;
                    else                        m_trend[i] = 0;
                    m_fb[i]   = !m_seen[i] || (sps >= m_psps[i]);
                    m_phr[i]  = hr;
                    m_psps[i] = sps;
                    m_seen[i] = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                chk($sformatf("steps%0d", i), 64'(total_steps[i*16 +: 16]), 64'(m_steps[i]));
                chk($sformatf("dist%0d", i), 64'(total_distance[i*DW +: DW]), 64'(m_dist[i]));
                chk($sformatf("time%0d", i), 64'(time_elapsed[i*8 +: 8]), 64'(m_time[i]));
                chk($sformatf("maxhr%0d", i), 64'(max_hr[i*8 +: 8]), 64'(m_max[i]));
                chk($sformatf("trend%0d", i), 64'(hr_trend[i*2 +: 2]), 64'(m_trend[i]));
                chk($sformatf("fb%0d", i), 64'(step_feedback[i]), 64'(m_fb[i]));
                chk($sformatf("sat%0d", i), 64'(sat_flag[i]), 64'(m_sat[i]));
            end
            chk("busy", 64'(rpt.report_busy), 64'(m_cnt >= 2));
            chk("valid", 64'(rpt.report_valid), 64'(m_cnt == 1));
            chk("lidx", 64'(rpt.leader_idx), 64'(m_lidx));
            chk("ldist", 64'(rpt.leader_distance), 64'(m_ldist));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic samp(input int ch, input int hr, input int sps, input int stride);
        hr_in[ch*8 +: 8]     = 8'(hr);
        sps_in[ch*3 +: 3]    = 3'(sps);
        stride_in[ch*8 +: 8] = 8'(stride);
        sample_valid[ch]     = 1'b1;
    endtask

    int hrs[4]   = '{110, 121, 120, 108};
    int spss[4]  = '{1, 2, 3, 4};
    int trends[4] = '{0, 1, 0, 2};
    int pulses, vk, lidx_seen, ldist_seen;

    initial begin
        rst = 1'b1; sample_valid = '0; clear_run = '0;
        hr_in = '0; sps_in = '0; stride_in = '0; rpt.report_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_steps", 64'(total_steps), 64'd0);
        chk("rst_busy", 64'(rpt.report_busy), 64'd0);
        chk("rst_ldist", 64'(rpt.leader_distance), 64'd0);
        chk("rst_sat", 64'(sat_flag), 64'd0);

        // All-zero report: leader 0 / 0, valid on the 5th cycle
        rpt.report_req = 1'b1; tick(); rpt.report_req = 1'b0;
        repeat (4) tick();
        chk("zero_valid", 64'(rpt.report_valid), 64'd1);
        chk("zero_lidx", 64'(rpt.leader_idx), 64'd0);
        chk("zero_ldist", 64'(rpt.leader_distance), 64'd0);
        tick();

        for (int k = 0; k < 4; k++) begin
            samp(0, hrs[k], spss[k], 75); tick(); sample_valid = '0;
            chk($sformatf("trend_s%0d", k), 64'(hr_trend[1:0]), 64'(trends[k]));
            chk($sformatf("fb_s%0d", k), 64'(step_feedback[0]), 64'd1);
        end
        chk("steps10", 64'(total_steps[15:0]), 64'd10);
        chk("dist750", 64'(total_distance[DW-1:0]), 64'd750);
        chk("time4", 64'(time_elapsed[7:0]), 64'd4);
        chk("max121", 64'(max_hr[7:0]), 64'd121);

        samp(0, 108, 4, 75); tick(); sample_valid = '0;
        chk("fb_eq", 64'(step_feedback[0]), 64'd1);
        samp(0, 108, 3, 75); tick(); sample_valid = '0;
        chk("fb_slow", 64'(step_feedback[0]), 64'd0);

        samp(0, 200, 5, 75); clear_run[0] = 1'b1; tick();
        sample_valid = '0; clear_run = '0;
        chk("clr_steps", 64'(total_steps[15:0]), 64'd0);
        chk("clr_dist", 64'(total_distance[DW-1:0]), 64'd0);
        chk("clr_max", 64'(max_hr[7:0]), 64'd0);

        // Distances 300, 900, 900, 100 loaded in one simultaneous sample
        samp(0, 100, 3, 100); samp(1, 100, 6, 150); samp(2, 100, 4, 225); samp(3, 100, 1, 100);
        tick(); sample_valid = '0;
        chk("dist900", 64'(total_distance[2*DW-1:DW]), 64'd900);
        rpt.report_req = 1'b1; tick(); rpt.report_req = 1'b0;
        pulses = 0; vk = 0; lidx_seen = 0; ldist_seen = 0;
        for (int k = 1; k <= 8; k++) begin
            if (rpt.report_valid) begin
                pulses++; vk = k;
                lidx_seen = int'(rpt.leader_idx); ldist_seen = int'(rpt.leader_distance);
            end
            if (k == 2) rpt.report_req = 1'b1;
            if (k == 3) begin rpt.report_req = 1'b0; samp(3, 100, 7, 255); end
            if (k == 4) sample_valid = '0;
            tick();
        end
        chk("rep_pulses", 64'(pulses), 64'd1);
        chk("rep_latency", 64'(vk), 64'd5);
        chk("rep_lidx", 64'(lidx_seen), 64'd1);
        chk("rep_ldist", 64'(ldist_seen), 64'd900);

        clear_run[0] = 1'b1; tick(); clear_run = '0;
        for (int k = 0; k < 3; k++) begin samp(0, 100, 7, 255); tick(); end
        sample_valid = '0;
        chk("sat_dist", 64'(total_distance[DW-1:0]), 64'd4095);
        chk("sat_flag0", 64'(sat_flag[0]), 64'd1);
        chk("sat_ch1_dist", 64'(total_distance[2*DW-1:DW]), 64'd900);
        chk("sat_flag1", 64'(sat_flag[1]), 64'd0);
        clear_run[0] = 1'b1; tick(); clear_run = '0;
        chk("sat_clr", 64'(sat_flag[0]), 64'd0);

        // Reset two cycles into a scan
        rpt.report_req = 1'b1; tick(); rpt.report_req = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_busy", 64'(rpt.report_busy), 64'd0);
        chk("abort_steps", 64'(total_steps), 64'd0);
        chk("abort_dist", 64'(total_distance), 64'd0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (rpt.report_valid) pulses++;
            tick();
        end
        chk("abort_pulses", 64'(pulses), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
